// File: rtl/dpram_pkg.sv
// Shared types and constants for the parametrised dual-port RAM.
package dpram_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } dpram_state_e;

  localparam int WR_FIRST   = 0;
  localparam int RD_FIRST   = 1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read data/valid delay line; data holds between reads.
module dpram_rd_pipe
  import dpram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [DATA_W-1:0] data_q;

  if (RD_LAT == RD_LAT_MAX) begin : g_lat2
    logic              s1_vld_q;
    logic [DATA_W-1:0] s1_data_q;

    // Two-stage delay; each stage loads data only alongside a valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld_q  <= 1'b0;
        s1_data_q <= '0;
        vld_q     <= 1'b0;
        data_q    <= '0;
      end else begin
        s1_vld_q <= vld_i;
        vld_q    <= s1_vld_q;
        if (vld_i) begin
          s1_data_q <= data_i;
        end
        if (s1_vld_q) begin
          data_q <= s1_data_q;
        end
      end
    end
  end else begin : g_lat1
    // Single output register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        vld_q <= vld_i;
        if (vld_i) begin
          data_q <= data_i;
        end
      end
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/dpram_param.sv
// True dual-port RAM with clear-after-reset sequencer, configurable read
// latency, cross-port read-during-write policy and double-write arbitration.
module dpram_param
  import dpram_pkg::*;
#(
  parameter int    DATA_W         = 16,
  parameter int    ADDR_W         = 10,
  parameter int    RD_LAT         = 1,
  parameter int    WRITE_MODE     = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              busy,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("dpram_param: RD_LAT must be 1 or 2");
  end
  if ((WRITE_MODE != WR_FIRST) && (WRITE_MODE != RD_FIRST)) begin : g_bad_mode
    $error("dpram_param: WRITE_MODE must be 0 or 1");
  end
  if ((CLEAR_ON_RESET == 0) && (INIT_FILE != "")) begin : g_init_note
    $info("dpram_param: preload image %s comes from the memory init flow", INIT_FILE);
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  dpram_state_e      state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              busy_q;
  logic              collision_q;

  logic              a_wr_s, b_wr_s, a_rd_s, b_rd_s;
  logic              same_addr_s, b_wr_keep_s, clear_wr_s;
  logic [DATA_W-1:0] a_rd_data_s, b_rd_data_s;

  // Request decode, B-write drop on double write, and cross-port bypass.
  always_comb begin
    same_addr_s = (a_addr == b_addr);
    a_wr_s      = a_en && a_we && !busy_q;
    b_wr_s      = b_en && b_we && !busy_q;
    a_rd_s      = a_en && !a_we && !busy_q;
    b_rd_s      = b_en && !b_we && !busy_q;
    b_wr_keep_s = b_wr_s && !(a_wr_s && same_addr_s);
    clear_wr_s  = (CLEAR_ON_RESET != 0) &&
                  ((state_q == ST_RESET) || (state_q == ST_CLEAR));
    if ((WRITE_MODE == WR_FIRST) && b_wr_s && same_addr_s) begin
      a_rd_data_s = b_wdata;
    end else begin
      a_rd_data_s = mem_q[a_addr];
    end
    if ((WRITE_MODE == WR_FIRST) && a_wr_s && same_addr_s) begin
      b_rd_data_s = a_wdata;
    end else begin
      b_rd_data_s = mem_q[b_addr];
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (clear_wr_s) begin
      mem_q[clr_cnt_q] <= '0;
    end else begin
      if (b_wr_keep_s) begin
        mem_q[b_addr] <= b_wdata;
      end
      if (a_wr_s) begin
        mem_q[a_addr] <= a_wdata;
      end
    end
  end

  // Reset/clear sequencer. Address 0 is cleared on the RESET->CLEAR edge so
  // the last address lands exactly DEPTH edges after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RESET;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (CLEAR_ON_RESET != 0) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end else begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            state_q   <= ST_READY;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          end
        end
        ST_READY: begin
          busy_q <= 1'b0;
        end
        default: begin
          state_q   <= ST_RESET;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
      endcase
    end
  end

  // Registered double-write collision flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= a_wr_s && b_wr_s && same_addr_s;
    end
  end

  dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (a_rd_s),
    .data_i (a_rd_data_s),
    .vld_o  (a_rvalid),
    .data_o (a_rdata)
  );

  dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (b_rd_s),
    .data_i (b_rd_data_s),
    .vld_o  (b_rvalid),
    .data_o (b_rdata)
  );

  assign busy      = busy_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dpram_param.sv
// Scoreboard bench: two instances (write-first/RD_LAT=1 and read-first/RD_LAT=2)
// driven in lockstep, expected read words queued per port and popped on rvalid.
module tb_dpram_param;

  logic        clk;
  logic        rst_n;
  logic        a_en, a_we, b_en, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic [15:0] wf_a_rdata, wf_b_rdata, rf_a_rdata, rf_b_rdata;
  logic        wf_a_rvalid, wf_b_rvalid, rf_a_rvalid, rf_b_rvalid;
  logic        wf_busy, rf_busy, wf_coll, rf_coll;

  int checks;
  int failures;

  logic [15:0] exp_q [4][$];
  int          exp_coll [2];
  logic [15:0] rd_dat [4];
  logic        rd_vld [4];
  logic        coll   [2];

  dpram_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .WRITE_MODE(0),
                .CLEAR_ON_RESET(1), .INIT_FILE("")) u_wf (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(wf_a_rdata), .a_rvalid(wf_a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(wf_b_rdata), .b_rvalid(wf_b_rvalid),
    .busy(wf_busy), .collision(wf_coll)
  );

  dpram_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .WRITE_MODE(1),
                .CLEAR_ON_RESET(1), .INIT_FILE("")) u_rf (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(rf_a_rdata), .a_rvalid(rf_a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(rf_b_rdata), .b_rvalid(rf_b_rvalid),
    .busy(rf_busy), .collision(rf_coll)
  );

  assign rd_dat[0] = wf_a_rdata;  assign rd_vld[0] = wf_a_rvalid;
  assign rd_dat[1] = wf_b_rdata;  assign rd_vld[1] = wf_b_rvalid;
  assign rd_dat[2] = rf_a_rdata;  assign rd_vld[2] = rf_a_rvalid;
  assign rd_dat[3] = rf_b_rdata;  assign rd_vld[3] = rf_b_rvalid;
  assign coll[0]   = wf_coll;
  assign coll[1]   = rf_coll;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop the expected word on every rvalid, account every collision pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd_vld[i]) begin
        if (exp_q[i].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rvalid_unexpected port=%0d got=%0h required=none", i, rd_dat[i]);
        end else begin
          chk($sformatf("rdata_port%0d", i), {16'h0000, rd_dat[i]},
              {16'h0000, exp_q[i].pop_front()});
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (coll[i]) begin
        checks++;
        if (exp_coll[i] > 0) begin
          exp_coll[i]--;
        end else begin
          failures++;
          $display("FAIL collision_unexpected dut=%0d got=1 required=0", i);
        end
      end
    end
  end

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_addr = 4'h0; a_wdata = 16'h0000;
    b_en = 1'b0; b_we = 1'b0; b_addr = 4'h0; b_wdata = 16'h0000;
  endtask

  task automatic cyc(input logic ae, input logic aw, input logic [3:0] aa, input logic [15:0] ad,
                     input logic be, input logic bw, input logic [3:0] ba, input logic [15:0] bd);
    a_en = ae; a_we = aw; a_addr = aa; a_wdata = ad;
    b_en = be; b_we = bw; b_addr = ba; b_wdata = bd;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push_all(input int port_b, input logic [15:0] v_wf, input logic [15:0] v_rf);
    exp_q[port_b].push_back(v_wf);
    exp_q[port_b + 2].push_back(v_rf);
  endtask

  task automatic wait_ready(output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (n0 == 0 && !wf_busy) n0 = k;
      if (n1 == 0 && !rf_busy) n1 = k;
      if (n0 != 0 && n1 != 0) break;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy_wf"}, {31'd0, wf_busy}, 32'd1);
    chk({tag, "_busy_rf"}, {31'd0, rf_busy}, 32'd1);
    chk({tag, "_rdata_wf_a"}, {16'h0000, wf_a_rdata}, 32'd0);
    chk({tag, "_rdata_rf_a"}, {16'h0000, rf_a_rdata}, 32'd0);
    chk({tag, "_rdata_wf_b"}, {16'h0000, wf_b_rdata}, 32'd0);
    chk({tag, "_rvalid_any"}, {28'd0, wf_a_rvalid, wf_b_rvalid, rf_a_rvalid, rf_b_rvalid}, 32'd0);
    chk({tag, "_collision"}, {30'd0, wf_coll, rf_coll}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, n1;
    logic [4:0] wf_pat, rf_pat;
    checks = 0;
    failures = 0;
    exp_coll[0] = 0;
    exp_coll[1] = 0;
    idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");

    // Clear sequence after release, then every address reads zero.
    rst_n = 1'b1;
    wait_ready(n0, n1);
    chk("clear_cycles_wf", n0, 32'd16);
    chk("clear_cycles_rf", n1, 32'd16);
    for (int i = 0; i < 16; i++) begin
      push_all(0, 16'h0000, 16'h0000);
      push_all(1, 16'h0000, 16'h0000);
      cyc(1'b1, 1'b0, 4'(i), 16'h0000, 1'b1, 1'b0, 4'(15 - i), 16'h0000);
    end

    // Write on A, read back on B the next cycle.
    cyc(1'b1, 1'b1, 4'h5, 16'hBEEF, 1'b0, 1'b0, 4'h0, 16'h0000);
    push_all(1, 16'hBEEF, 16'hBEEF);
    cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'h5, 16'h0000);

    // Same-cycle write on A and read on B: new data vs old data.
    cyc(1'b1, 1'b1, 4'hA, 16'h0042, 1'b0, 1'b0, 4'h0, 16'h0000);
    push_all(1, 16'h1234, 16'h0042);
    cyc(1'b1, 1'b1, 4'hA, 16'h1234, 1'b1, 1'b0, 4'hA, 16'h0000);
    push_all(1, 16'h1234, 16'h1234);
    cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0, 4'hA, 16'h0000);

    // Double write: A wins, one collision pulse per instance.
    exp_coll[0]++;
    exp_coll[1]++;
    cyc(1'b1, 1'b1, 4'h3, 16'hAAAA, 1'b1, 1'b1, 4'h3, 16'h5555);
    push_all(0, 16'hAAAA, 16'hAAAA);
    cyc(1'b1, 1'b0, 4'h3, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);

    cyc(1'b1, 1'b1, 4'h1, 16'h0011, 1'b0, 1'b0, 4'h0, 16'h0000);
    cyc(1'b1, 1'b1, 4'h2, 16'h0022, 1'b0, 1'b0, 4'h0, 16'h0000);
    cyc(1'b1, 1'b1, 4'h3, 16'h0033, 1'b0, 1'b0, 4'h0, 16'h0000);
    repeat (3) cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);

    // Back-to-back reads; record rvalid after each of five edges.
    push_all(0, 16'h0011, 16'h0011);
    push_all(0, 16'h0022, 16'h0022);
    push_all(0, 16'h0033, 16'h0033);
    cyc(1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    wf_pat[4] = wf_a_rvalid; rf_pat[4] = rf_a_rvalid;
    cyc(1'b1, 1'b0, 4'h2, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    wf_pat[3] = wf_a_rvalid; rf_pat[3] = rf_a_rvalid;
    cyc(1'b1, 1'b0, 4'h3, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    wf_pat[2] = wf_a_rvalid; rf_pat[2] = rf_a_rvalid;
    cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    wf_pat[1] = wf_a_rvalid; rf_pat[1] = rf_a_rvalid;
    cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    wf_pat[0] = wf_a_rvalid; rf_pat[0] = rf_a_rvalid;
    chk("rvalid_train_lat1", {27'd0, wf_pat}, 32'h1C);
    chk("rvalid_train_lat2", {27'd0, rf_pat}, 32'h0E);

    // A write yields no rvalid and leaves rdata untouched.
    cyc(1'b1, 1'b1, 4'h9, 16'h7777, 1'b1, 1'b1, 4'h8, 16'h6666);
    repeat (2) cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    chk("rdata_hold_wf", {16'h0000, wf_a_rdata}, 32'h0033);
    chk("rdata_hold_rf", {16'h0000, rf_a_rdata}, 32'h0033);

    // Asynchronous reset from READY clears outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_ready");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("midclear_busy_wf", {31'd0, wf_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_midclear");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n0, n1);
    chk("reclear_cycles_wf", n0, 32'd16);
    chk("reclear_cycles_rf", n1, 32'd16);

    push_all(0, 16'h0000, 16'h0000);
    push_all(1, 16'h0000, 16'h0000);
    cyc(1'b1, 1'b0, 4'h5, 16'h0000, 1'b1, 1'b0, 4'h9, 16'h0000);
    repeat (4) cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reads_outstanding_port%0d", i), exp_q[i].size(), 32'd0);
    end
    chk("collisions_missing_wf", exp_coll[0], 32'd0);
    chk("collisions_missing_rf", exp_coll[1], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
